// File: rtl/serial_tx_frame.sv
// Parametrised frame serializer: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// Optional parity bit is compiled in when SERIAL_TX_FRAME_PARITY_EN is defined.
module serial_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0,
    parameter int START_LEVEL  = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data,
    output logic              txd,
    output logic              busy,
    output logic              done,
    output logic              ovr
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          START_LVL = (START_LEVEL != 0);
    localparam logic          IDLE_LVL  = (START_LEVEL == 0);
    localparam logic          MSB_F     = (MSB_FIRST != 0);

    if (DATA_W < 1 || DATA_W > 32 || CLKS_PER_BIT < 1 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("serial_tx_frame: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_FRAME_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              prev_q;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
`ifdef SERIAL_TX_FRAME_PARITY_EN
    localparam logic   PAR_ODD = (PARITY_ODD != 0);
    logic              par_q, par_d;
`endif

    logic              edge_w;
    logic              bit_end;
    logic              next_bit;
    logic [DATA_W-1:0] shift_adv;

    assign edge_w    = send & ~prev_q;
    assign bit_end   = (cnt_q == CNT_LAST);
    // The shift register always presents the next bit to send at one fixed end.
    assign next_bit  = MSB_F ? shift_q[DATA_W-1] : shift_q[0];
    assign shift_adv = MSB_F ? (shift_q << 1) : (shift_q >> 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
        par_d   = par_q;
`endif

        // Any launch edge outside IDLE is dropped, including the STOP-completion clock.
        if (edge_w && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                txd_d  = IDLE_LVL;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (edge_w) begin
                    shift_d = data;
                    state_d = S_START;
                    txd_d   = START_LVL;
                    busy_d  = 1'b1;
`ifdef SERIAL_TX_FRAME_PARITY_EN
                    par_d   = (^data) ^ PAR_ODD;
`endif
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    txd_d   = next_bit;
                    shift_d = shift_adv;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef SERIAL_TX_FRAME_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = par_q;
`else
                        state_d = S_STOP;
                        txd_d   = IDLE_LVL;
`endif
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        txd_d   = next_bit;
                        shift_d = shift_adv;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

`ifdef SERIAL_TX_FRAME_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    txd_d   = IDLE_LVL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif

            S_STOP: begin
                // idx_q counts stop bits here so no extra wide counter is needed.
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = IDLE_LVL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b0;
            txd_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            prev_q  <= send;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SERIAL_TX_FRAME_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovr  = ovr_q;

endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
- Parametrised successor to the fixed 8-bit, one-bit-per-clock frame serializer.
- A rising edge on send captures a DATA_W-bit word. The word is shifted out on txd as: start bit, data bits, optional parity, then 1 or 2 stop bits. Each bit lasts CLKS_PER_BIT clocks.
- Adds a busy/done/overrun handshake and selectable bit order.
- Sits between the control logic that issues words and the board's serial output pin.

Parameters:
DATA_W, 8, data word width; legal 1..32
CLKS_PER_BIT, 1, clocks per transmitted bit; legal >=1
STOP_BITS, 1, number of stop bits; legal 1 or 2
MSB_FIRST, 0, 0 = LSB first, 1 = MSB first
START_LEVEL, 1, txd level of the start bit; stop and idle level is ~START_LEVEL
PARITY_ODD, 0, parity sense (used only with SERIAL_TX_FRAME_PARITY_EN): 0 even, 1 odd

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
send  input  1  request; a 0->1 transition launches a frame
data  input  DATA_W  word, sampled only on the launch edge
txd  output  1  registered serial output
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at frame completion
ovr  output  1  one-cycle pulse when a send edge is dropped

Behaviour:
- Reset (asynchronous, active-high):
  - txd=~START_LEVEL, busy=0, done=0, ovr=0.
  - State=IDLE; send-history register=0; all counters and the shift register cleared.
  - Reset asserted mid-frame aborts the frame immediately; the partial frame is not resumed.
- Edge detect:
  - prev register samples send on every clock, in all states.
  - edge = send & ~prev.
  - send already high at reset release counts as an edge on the first clock.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - txd=~START_LEVEL, busy=0.
  - On a clock with edge=1: latch data into the shift register; state->START; txd<=START_LEVEL; busy<=1. The start bit therefore appears on txd directly after the launch edge; latency 0 extra cycles.
- START:
  - Hold for CLKS_PER_BIT clocks, then ->DATA.
  - The first data bit is the word LSB if MSB_FIRST=0, else the MSB.
- DATA:
  - Each bit is held CLKS_PER_BIT clocks.
  - Bit counter runs 0..DATA_W-1.
  - After the last bit: ->PARITY if the macro is defined, else ->STOP.
- STOP:
  - txd=~START_LEVEL for STOP_BITS*CLKS_PER_BIT clocks, then ->IDLE.
  - On the clock entering IDLE: busy<=0 and done<=1 for one cycle.
- Frame length in clocks: (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT, where P=1 with the macro, else 0. With defaults and no macro this is 10.
- Overrun:
  - An edge while state != IDLE is dropped: ovr<=1 for one cycle; the frame in progress is unaffected; data is not re-sampled.
  - This includes an edge on the same clock that STOP completes. No queueing.
- Back-to-back: a new edge on the first clock with busy=0 launches immediately, so the minimum idle gap is 1 clock.
- Counters:
  - Bit-time counter width clog2(CLKS_PER_BIT), minimum 1.
  - Bit-index counter width clog2(DATA_W+1).
  - No wrap-around is exposed; counters reset on each state change.
- Changes to data while busy have no effect.

Optional Feature:
- Macro: SERIAL_TX_FRAME_PARITY_EN.
- Defined:
  - PARITY state after DATA, one bit time.
  - txd = ^latched_word ^ PARITY_ODD (even parity: total ones across data+parity is even when PARITY_ODD=0).
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Defaults, data=8'hA5, pulse send -> txd over 10 clocks = 1, 1,0,1,0,0,1,0,1, 0; busy high for 10 clocks; done pulses once on clock 11; ovr=0.
- MSB_FIRST=1, DATA_W=4, CLKS_PER_BIT=3, data=4'hC -> start 1 for 3 clks; bits 1,1,0,0 each held 3 clks; stop 0 for 3 clks; total 18 clks.
- STOP_BITS=2, data=8'hFF, second send edge at clock 5 -> ovr pulses at clock 5; frame unchanged, 11 clks; data sampled at clock 5 ignored.
- Macro defined, PARITY_ODD=0, data=8'h07 -> parity bit 1 after the data bits; frame 11 clks. With PARITY_ODD=1 -> parity bit 0.
- Assert rst at clock 4 of a frame -> txd=0, busy=0 immediately, without waiting for a clock edge. After release with send held high -> a new frame launches on the first clock.
- send kept high through two frames (defaults) -> exactly one frame, no ovr. Drop send, raise it on the first clock after done -> second frame starts on that clock.
